// File: rtl/cruiser_wheel_pkg.sv
// Shared state encoding and direction constants for the Cyclone Cruiser wheel controllers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cruiser_wheel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BRAKE = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    // A one-cycle timer still needs a one-bit register.
    function automatic int timer_width(input int cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/wheel_move_ctrl_if.sv
// Command/status bundle between a move requester and wheel_move_ctrl.
// Latency: n/a (wires only).
// Backpressure: start is only honoured while the controller is idle; busy/done report progress.
interface wheel_move_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic             dir_req;
    logic [CNT_W-1:0] target_steps;
    logic             step_cw;
    logic             step_ccw;
    logic             motor_en;
    logic             motor_dir;
    logic             busy;
    logic             done;
    logic             err_stall;
    logic             err_dir;
    logic [CNT_W-1:0] steps_done;
    logic [CNT_W-1:0] position;

    modport master (
        output start, abort, dir_req, target_steps, step_cw, step_ccw,
        input  motor_en, motor_dir, busy, done, err_stall, err_dir, steps_done, position
    );

    modport slave (
        input  start, abort, dir_req, target_steps, step_cw, step_ccw,
        output motor_en, motor_dir, busy, done, err_stall, err_dir, steps_done, position
    );
endinterface

// File: rtl/wheel_cycle_timer.sv
// Down-counter that expires after CYC ticks following a load; holds at zero once expired.
// Latency: expire is high on the CYC-th tick after load.
// Backpressure: none; the caller gates tick.
module wheel_cycle_timer
    import cruiser_wheel_pkg::*;
#(
    parameter int CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic tick,
    output logic expire
);
    localparam int           W        = timer_width(CYC);
    localparam logic [W-1:0] LOAD_VAL = W'(CYC - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= LOAD_VAL;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/wheel_move_ctrl.sv
// Wheel move controller: runs a directed step count, tracks signed position, flags stall/wrong direction.
// Latency: all outputs registered; motor_en/busy follow an accepted start by one cycle.
// Backpressure: start ignored unless idle; abort honoured only while running.
module wheel_move_ctrl
    import cruiser_wheel_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int STALL_CYC = 50000000,
    parameter int BRAKE_CYC = 5000000
) (
    input  logic              clk,
    input  logic              reset,
    wheel_move_ctrl_if.slave  bus
);
    state_t           state, next_state;
    logic [CNT_W-1:0] target_q, steps_q, pos_q;
    logic             dir_q, en_q, busy_q, done_q, err_stall_q, err_dir_q;
    logic             cw_only, ccw_only, valid_step, wrong_step, step_last;
    logic             start_acc, stall_exp, stall_hit, brake_exp;

    // Simultaneous cw and ccw pulses cancel: no motion, no progress, no error.
    assign cw_only    = bus.step_cw & ~bus.step_ccw;
    assign ccw_only   = bus.step_ccw & ~bus.step_cw;
    assign start_acc  = (state == ST_IDLE) & bus.start;
    assign valid_step = (state == ST_RUN) & ((dir_q == DIR_CW)  ? cw_only : ccw_only);
    assign wrong_step = (state == ST_RUN) & ((dir_q == DIR_CCW) ? cw_only : ccw_only);
    assign step_last  = ((steps_q + 1'b1) == target_q);
    assign stall_hit  = (state == ST_RUN) & ~valid_step & ~bus.abort & stall_exp;

    wheel_cycle_timer #(.CYC(STALL_CYC)) u_stall_timer (
        .clk    (clk),
        .reset  (reset),
        .load   ((state != ST_RUN) || valid_step),
        .tick   ((state == ST_RUN) && !valid_step),
        .expire (stall_exp)
    );

    wheel_cycle_timer #(.CYC(BRAKE_CYC)) u_brake_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (state != ST_BRAKE),
        .tick   (state == ST_BRAKE),
        .expire (brake_exp)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Run priority: valid step, then abort, then stall.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    next_state = (bus.target_steps == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (valid_step) begin
                    if (step_last) next_state = ST_BRAKE;
                end else if (bus.abort) begin
                    next_state = ST_BRAKE;
                end else if (stall_exp) begin
                    next_state = ST_FIN;
                end
            end
            ST_BRAKE: begin
                if (brake_exp) next_state = ST_FIN;
            end
            ST_FIN:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_q    <= '0;
            steps_q     <= '0;
            pos_q       <= '0;
            dir_q       <= 1'b0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_stall_q <= 1'b0;
            err_dir_q   <= 1'b0;
        end else begin
            en_q   <= (next_state == ST_RUN);
            busy_q <= (next_state != ST_IDLE);
            done_q <= (state == ST_FIN);
            if (start_acc) begin
                target_q    <= bus.target_steps;
                dir_q       <= bus.dir_req;
                steps_q     <= '0;
                err_stall_q <= 1'b0;
                err_dir_q   <= 1'b0;
            end else begin
                if (valid_step) steps_q     <= steps_q + 1'b1;
                if (wrong_step) err_dir_q   <= 1'b1;
                if (stall_hit)  err_stall_q <= 1'b1;
            end
            if (cw_only) begin
                pos_q <= pos_q + 1'b1;
            end else if (ccw_only) begin
                pos_q <= pos_q - 1'b1;
            end
        end
    end

    assign bus.motor_en   = en_q;
    assign bus.motor_dir  = dir_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err_stall  = err_stall_q;
    assign bus.err_dir    = err_dir_q;
    assign bus.steps_done = steps_q;
    assign bus.position   = pos_q;

endmodule

// File: tb/tb_wheel_move_ctrl.sv
// Bench for wheel_move_ctrl: directed scenarios with literal expectations, then random traffic
// checked every cycle against a phase/counter model of the move rules.
module tb_wheel_move_ctrl;
    localparam int CNT_W     = 8;
    localparam int STALL_CYC = 20;
    localparam int BRAKE_CYC = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_BRAKE = 2, M_FIN = 3;
    localparam int POS_MASK = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    wheel_move_ctrl_if #(.CNT_W(CNT_W)) bus ();

    wheel_move_ctrl #(
        .CNT_W     (CNT_W),
        .STALL_CYC (STALL_CYC),
        .BRAKE_CYC (BRAKE_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: visible phase plus plain counters.
    int m_phase  = M_IDLE;
    int m_target = 0;
    int m_steps  = 0;
    int m_pos    = 0;
    int m_quiet  = 0;
    int m_brake  = 0;
    bit m_dir    = 1'b0;
    bit m_err_s  = 1'b0;
    bit m_err_d  = 1'b0;
    bit m_done   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = M_IDLE; m_target = 0; m_steps = 0; m_pos = 0;
            m_quiet = 0; m_brake = 0; m_dir = 1'b0;
            m_err_s = 1'b0; m_err_d = 1'b0; m_done = 1'b0;
        end else begin
            bit cw, ccw, valid, wrong;
            cw     = bus.step_cw && !bus.step_ccw;
            ccw    = bus.step_ccw && !bus.step_cw;
            m_done = (m_phase == M_FIN);
            if (cw)  m_pos = (m_pos + 1) & POS_MASK;
            if (ccw) m_pos = (m_pos - 1) & POS_MASK;
            case (m_phase)
                M_IDLE: if (bus.start) begin
                    m_target = int'(bus.target_steps);
                    m_dir    = bus.dir_req;
                    m_steps  = 0; m_quiet = 0;
                    m_err_s  = 1'b0; m_err_d = 1'b0;
                    m_phase  = (m_target == 0) ? M_FIN : M_RUN;
                end
                M_RUN: begin
                    valid = m_dir ? cw : ccw;
                    wrong = m_dir ? ccw : cw;
                    if (wrong) m_err_d = 1'b1;
                    if (valid) begin
                        m_steps++;
                        m_quiet = 0;
                        if (m_steps == m_target) begin
                            m_phase = M_BRAKE; m_brake = BRAKE_CYC;
                        end
                    end else if (bus.abort) begin
                        m_phase = M_BRAKE; m_brake = BRAKE_CYC;
                    end else begin
                        m_quiet++;
                        if (m_quiet == STALL_CYC) begin
                            m_err_s = 1'b1; m_phase = M_FIN;
                        end
                    end
                end
                M_BRAKE: begin
                    m_brake--;
                    if (m_brake == 0) m_phase = M_FIN;
                end
                default: m_phase = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("motor_en",   bus.motor_en,   m_phase == M_RUN);
        chk("motor_dir",  bus.motor_dir,  m_dir);
        chk("busy",       bus.busy,       m_phase != M_IDLE);
        chk("done",       bus.done,       m_done);
        chk("err_stall",  bus.err_stall,  m_err_s);
        chk("err_dir",    bus.err_dir,    m_err_d);
        chk("steps_done", bus.steps_done, m_steps);
        chk("position",   bus.position,   m_pos);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int k;
        k = 0;
        while (bus.done !== 1'b1 && k < 200) begin
            cyc(1);
            k++;
        end
        chk(name, k, exp_lat);
    endtask

    task automatic cmd(input logic dir, input int tgt);
        bus.start        = 1'b1;
        bus.dir_req      = dir;
        bus.target_steps = CNT_W'(tgt);
        cyc(1);
        bus.start        = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.dir_req = 1'b0;
        bus.target_steps = '0; bus.step_cw = 1'b0; bus.step_ccw = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_motor_en", bus.motor_en, 0);
        chk("rst_busy",     bus.busy,     0);
        chk("rst_position", bus.position, 0);
        cyc(3);
        reset = 1'b0;
        cyc(2);

        // Clockwise move of 3 steps, pulses 5 cycles apart.
        cmd(1'b1, 3);
        chk("t1_motor_en", bus.motor_en, 1);
        chk("t1_busy",     bus.busy,     1);
        for (int i = 0; i < 3; i++) begin
            cyc(4);
            bus.step_cw = 1'b1;
            cyc(1);
            bus.step_cw = 1'b0;
        end
        chk("t1_motor_off", bus.motor_en, 0);
        wait_done("t1_done_lat", BRAKE_CYC + 1);
        chk("t1_steps",    bus.steps_done, 3);
        chk("t1_position", bus.position,   3);
        chk("t1_errs",     {bus.err_stall, bus.err_dir}, 0);
        cyc(2);

        // No steps: stall after STALL_CYC run cycles, straight to done.
        cmd(1'b0, 2);
        wait_done("t2_stall_lat", STALL_CYC + 1);
        chk("t2_err_stall", bus.err_stall,  1);
        chk("t2_steps",     bus.steps_done, 0);
        cyc(2);

        // Wrong-direction step then two good ones.
        cmd(1'b1, 2);
        cyc(2); bus.step_ccw = 1'b1; cyc(1); bus.step_ccw = 1'b0;
        chk("t3_err_dir", bus.err_dir, 1);
        cyc(2); bus.step_cw = 1'b1; cyc(1); bus.step_cw = 1'b0;
        cyc(2); bus.step_cw = 1'b1; cyc(1); bus.step_cw = 1'b0;
        wait_done("t3_done_lat", BRAKE_CYC + 1);
        chk("t3_steps",    bus.steps_done, 2);
        chk("t3_position", bus.position,   4);
        cyc(2);

        // Zero target: no motor, done two edges after start is driven.
        cmd(1'b1, 0);
        chk("t4_motor_en", bus.motor_en, 0);
        chk("t4_err_clr",  bus.err_dir,  0);
        wait_done("t4_done_lat", 1);
        cyc(2);

        // Abort coinciding with a valid step loses; next-cycle abort brakes.
        cmd(1'b1, 5);
        cyc(2);
        bus.step_cw = 1'b1; bus.abort = 1'b1;
        cyc(1);
        bus.step_cw = 1'b0;
        chk("t5_step_wins", bus.steps_done, 1);
        chk("t5_still_run", bus.motor_en,   1);
        cyc(1);
        bus.abort = 1'b0;
        chk("t5_brake_en",  bus.motor_en, 0);
        cmd(1'b0, 9);
        chk("t5_busy_start", bus.motor_dir, 1);
        wait_done("t5_done_lat", BRAKE_CYC);
        chk("t5_steps_held", bus.steps_done, 1);
        cyc(1);
        chk("t5_no_queue", bus.busy, 0);

        // Cancelling pulses, reset mid-run, then wrap 0x7F -> 0x80.
        bus.step_cw = 1'b1; bus.step_ccw = 1'b1;
        cyc(1);
        bus.step_cw = 1'b0; bus.step_ccw = 1'b0;
        chk("t6_both_pulses", bus.position, 5);
        cmd(1'b1, 10);
        cyc(2);
        reset = 1'b1;
        #1;
        chk("t6_rst_en",    bus.motor_en,   0);
        chk("t6_rst_busy",  bus.busy,       0);
        chk("t6_rst_pos",   bus.position,   0);
        chk("t6_rst_steps", bus.steps_done, 0);
        cyc(2);
        reset = 1'b0;
        cyc(1);
        chk("t6_no_done", bus.done, 0);
        bus.step_cw = 1'b1;
        cyc(127);
        chk("t6_pos_7f", bus.position, 8'h7f);
        cyc(1);
        bus.step_cw = 1'b0;
        chk("t6_pos_wrap", bus.position, 8'h80);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bus.start        = ($urandom_range(0, 15) == 0);
            bus.dir_req      = 1'($urandom_range(0, 1));
            bus.target_steps = CNT_W'($urandom_range(0, 6));
            bus.step_cw      = ($urandom_range(0, 5) == 0);
            bus.step_ccw     = ($urandom_range(0, 5) == 0);
            bus.abort        = ($urandom_range(0, 49) == 0);
            reset            = ($urandom_range(0, 1499) == 0);
            cyc(1);
        end
        reset = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.step_cw = 1'b0; bus.step_ccw = 1'b0;
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
